// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a 4-entry byte FIFO.
// Frames go out back-to-back while bytes are queued; ovf latches any dropped write.
module uart_tx_fifo #(
    parameter int unsigned ClkFrq = 25000000,
    parameter int unsigned Baud   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic [2:0] count,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned BitCycles = ClkFrq / Baud;
    localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BitCycles - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [4];
    logic [1:0]      head, tail;
    logic [CntW-1:0] cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [2:0]      count_n;
    logic            tx_n;
    logic            push_c;
    logic            pop_c;
    logic            bit_end_c;

    // full is the registered pre-edge value, so a dropped write never races a pop
    assign push_c    = wr_en && !full;
    assign bit_end_c = (cnt == CntMax);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CntW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx;
        pop_c   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (!empty) begin
                    pop_c   = 1'b1;
                    shreg_n = mem[head];
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end_c) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                tx_n = shreg[0];
                if (bit_end_c) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n   = idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_end_c) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop_c   = 1'b1;
                        shreg_n = mem[head];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
        count_n = count + {2'b00, push_c} - {2'b00, pop_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
            head  <= head + {1'b0, pop_c};
            tail  <= tail + {1'b0, push_c};
            count <= count_n;
            full  <= (count_n == 3'd4);
            empty <= (count_n == 3'd0);
            busy  <= (state_n != IDLE);
            ovf   <= ovf | (wr_en & full);
        end
    end

    // Storage needs no reset; occupancy is tracked by count and the pointers
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[tail] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a line monitor decodes every frame and
// scores it against a queue of expected bytes.
module tb_uart_tx_fifo;

    localparam int Bc = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx, full, empty, busy, ovf;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    logic       mon_act = 1'b0;
    logic       rst_seen;
    logic       eb;
    int         mpos, mbad;
    logic [7:0] mexp, mrx;

    uart_tx_fifo #(.ClkFrq(16), .Baud(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .full(full), .empty(empty), .count(count),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Decode the line 1 time unit after each edge; reset seen at the edge aborts a frame
    always @(posedge clk) begin
        rst_seen = !rst_n;
        cyc++;
        #1;
        if (rst_seen) begin
            mon_act = 1'b0;
        end else if (!mon_act && tx === 1'b0) begin
            mon_act = 1'b1;
            mpos = 0;
            mbad = 0;
            mrx = 8'h00;
            start_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got a start bit expected none (t=%0t)", $time);
                mexp = 8'h00;
            end else begin
                mexp = exp_q.pop_front();
            end
        end
        if (mon_act) begin
            if (mpos < Bc) eb = 1'b0;
            else if (mpos < 9 * Bc) eb = mexp[(mpos / Bc) - 1];
            else eb = 1'b1;
            if (tx !== eb) mbad++;
            if (mpos >= Bc && mpos < 9 * Bc && (mpos % Bc) == Bc / 2)
                mrx[(mpos / Bc) - 1] = tx;
            if (mpos == 10 * Bc - 1) begin
                check("frame_bit_errors", 32'(mbad), 32'd0);
                check("frame_byte", 32'(mrx), 32'(mexp));
                frames++;
                mon_act = 1'b0;
            end else begin
                mpos++;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_q.delete();
        tick(1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(busy === 1'b0 && empty === 1'b1 && !mon_act) && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic write(input logic [7:0] b, input logic expect_sent);
        if (expect_sent) exp_q.push_back(b);
        wr_en = 1'b1;
        wr_data = b;
        tick(1);
    endtask

    initial begin
        int fb;

        // reset values
        tick(2);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // single byte 0xA5; wr_data changed after the accepting edge
        write(8'hA5, 1'b1);
        wr_en = 1'b0;
        wr_data = 8'hFF;
        check("t1_count_after_write", 32'(count), 32'd1);
        check("t1_empty_after_write", 32'(empty), 32'd0);
        check("t1_tx_still_idle", 32'(tx), 32'd1);
        tick(1);
        check("t1_tx_start", 32'(tx), 32'd0);
        check("t1_busy_start", 32'(busy), 32'd1);
        check("t1_empty_after_pop", 32'(empty), 32'd1);
        tick(159);
        check("t1_busy_last_cycle", 32'(busy), 32'd1);
        check("t1_tx_stop", 32'(tx), 32'd1);
        tick(1);
        check("t1_busy_cleared", 32'(busy), 32'd0);
        wait_idle(50);

        // six consecutive writes: one popped, four queued, one dropped
        do_reset();
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            write(8'(8'h11 * (i + 1)), i < 5);
            if (i == 4) begin
                check("t2_count_full", 32'(count), 32'd4);
                check("t2_full", 32'(full), 32'd1);
                check("t2_ovf_before_drop", 32'(ovf), 32'd0);
            end
        end
        wr_en = 1'b0;
        check("t2_ovf_set", 32'(ovf), 32'd1);
        check("t2_count_after_drop", 32'(count), 32'd4);
        wait_idle(1000);
        check("t2_frames", 32'(start_q.size()), 32'd5);
        for (int k = 1; k < 5 && k < start_q.size(); k++)
            check("t2_frame_spacing", 32'(start_q[k] - start_q[k-1]), 32'd160);
        check("t2_ovf_sticky", 32'(ovf), 32'd1);

        // write while full on the very edge a STOP ends and pops
        do_reset();
        for (int i = 0; i < 5; i++) write(8'(8'hA0 + i), 1'b1);
        wr_en = 1'b0;
        tick(156);
        check("t3_count_pre", 32'(count), 32'd4);
        check("t3_full_pre", 32'(full), 32'd1);
        check("t3_ovf_pre", 32'(ovf), 32'd0);
        write(8'hEE, 1'b0);
        wr_en = 1'b0;
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_count", 32'(count), 32'd3);
        check("t3_full", 32'(full), 32'd0);
        check("t3_next_start", 32'(tx), 32'd0);
        wait_idle(1000);

        // write and pop coincide at count 3
        do_reset();
        for (int i = 0; i < 4; i++) write(8'(8'hB0 + i), 1'b1);
        wr_en = 1'b0;
        check("t4_count_pre", 32'(count), 32'd3);
        tick(157);
        write(8'hB4, 1'b1);
        wr_en = 1'b0;
        check("t4_count_same", 32'(count), 32'd3);
        check("t4_ovf", 32'(ovf), 32'd0);
        wait_idle(1000);

        // reset mid-DATA with two bytes queued
        do_reset();
        for (int i = 0; i < 3; i++) write(8'(8'hC0 + i), 1'b1);
        wr_en = 1'b0;
        check("t5_count_pre", 32'(count), 32'd2);
        tick(40);
        fb = frames;
        rst_n = 1'b0;
        tick(1);
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        tick(400);
        check("t5_no_frames", 32'(frames - fb), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);

        // paced writes wrap the pointers
        do_reset();
        for (int i = 0; i < 10; i++) begin
            write(8'(i), 1'b1);
            wr_en = 1'b0;
            check("t6_count_le2", 32'(count <= 3'd2), 32'd1);
            tick(149);
        end
        wait_idle(2000);
        check("t6_ovf", 32'(ovf), 32'd0);
        check("all_bytes_sent", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
